// File: rtl/glycemic_pkg.sv
// Shared level encodings, FSM state type and sample range for the glycemic alarm path.
// Pure declarations: no latency and no backpressure.
package glycemic_pkg;
    localparam logic [1:0] LVL_LOW  = 2'b00;
    localparam logic [1:0] LVL_NORM = 2'b01;
    localparam logic [1:0] LVL_HIGH = 2'b10;

    localparam int MAX_INDEX = 8;

    typedef enum logic [1:0] {
        ST_NORM  = 2'b00,
        ST_HIGH  = 2'b01,
        ST_LOW   = 2'b10,
        ST_ALARM = 2'b11
    } state_t;
endpackage

// File: rtl/glycemic_alarm_sample_window.sv
// Clamp, moving-average window and fill tracking; average and update pulse one edge after the sample.
// Accepts a sample every cycle; there is no backpressure.
module sample_window
    import glycemic_pkg::*;
#(
    parameter int WINDOW_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [3:0] sample,
    output logic [3:0] avg_index,
    output logic       avg_valid,
    output logic       update
);
    localparam int DEPTH = 1 << WINDOW_LOG2;
    localparam int SW    = WINDOW_LOG2 + 4;
    localparam int FW    = WINDOW_LOG2 + 1;

    logic [3:0]    win [DEPTH];
    logic [SW-1:0] sum;
    logic [FW-1:0] fill;
    logic          upd_pend;
    logic [3:0]    clamped;

    assign clamped = (sample > 4'(MAX_INDEX)) ? 4'(MAX_INDEX) : sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum      <= '0;
            fill     <= '0;
            upd_pend <= 1'b0;
        end else begin
            // Pulse is armed by the sample that fills the window and every one after it.
            upd_pend <= sample_valid && (fill >= FW'(DEPTH - 1));
            if (sample_valid) begin
                win[0] <= clamped;
                for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
                sum <= sum + SW'(clamped) - SW'(win[DEPTH-1]);
                if (fill != FW'(DEPTH)) fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avg_index <= '0;
            avg_valid <= 1'b0;
            update    <= 1'b0;
        end else begin
            avg_index <= 4'(sum >> WINDOW_LOG2);
            avg_valid <= (fill == FW'(DEPTH));
            update    <= upd_pend;
        end
    end
endmodule

// File: rtl/glycemic_alarm.sv
// Smooths ones-count samples and classifies LOW/NORMAL/HIGH with hysteresis and a latched persistence alarm.
// avg two edges... avg_index one edge and level/alarm two edges after the sample; no backpressure.
module glycemic_alarm
    import glycemic_pkg::*;
#(
    parameter int WINDOW_LOG2 = 2,
    parameter int HIGH_TH     = 6,
    parameter int LOW_TH      = 2,
    parameter int PERSIST     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [3:0] glycemicIndex,
    input  logic       ack,
    output logic [3:0] avg_index,
    output logic       avg_valid,
    output logic [1:0] level,
    output logic       alarm
);
    localparam int         CW     = $clog2(PERSIST + 1);
    localparam logic [3:0] HI     = 4'(HIGH_TH);
    localparam logic [3:0] HI_EX  = 4'(HIGH_TH - 1);
    localparam logic [3:0] LO     = 4'(LOW_TH);
    localparam logic [3:0] LO_EX  = 4'(LOW_TH + 1);

    logic          update;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    level_nxt, cls;

    sample_window #(.WINDOW_LOG2(WINDOW_LOG2)) u_window (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (glycemicIndex),
        .avg_index    (avg_index),
        .avg_valid    (avg_valid),
        .update       (update)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_NORM;
            cnt   <= '0;
            level <= LVL_NORM;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
        end
    end

    assign alarm = (state == ST_ALARM);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        cls       = LVL_NORM;
        case (state)
            ST_HIGH: cls = (avg_index <= LO) ? LVL_LOW  : (avg_index < HI_EX) ? LVL_NORM : LVL_HIGH;
            ST_LOW:  cls = (avg_index >= HI) ? LVL_HIGH : (avg_index > LO_EX) ? LVL_NORM : LVL_LOW;
            default: cls = (avg_index >= HI) ? LVL_HIGH : (avg_index <= LO)   ? LVL_LOW  : LVL_NORM;
        endcase

        if (state == ST_ALARM) begin
            // Alarm ignores the average entirely; only acknowledge releases it.
            if (ack) begin
                state_nxt = ST_NORM;
                cnt_nxt   = '0;
                level_nxt = LVL_NORM;
            end
        end else if (update) begin
            level_nxt = cls;
            if (cls == LVL_NORM) begin
                state_nxt = ST_NORM;
                cnt_nxt   = '0;
            end else begin
                if ((cls == LVL_HIGH && state == ST_HIGH) || (cls == LVL_LOW && state == ST_LOW))
                    cnt_nxt = (cnt >= CW'(PERSIST)) ? cnt : cnt + 1'b1;
                else
                    cnt_nxt = CW'(1);
                if (cnt_nxt >= CW'(PERSIST))
                    state_nxt = ST_ALARM;
                else
                    state_nxt = (cls == LVL_HIGH) ? ST_HIGH : ST_LOW;
            end
        end
    end
endmodule

// File: tb/tb_glycemic_alarm.sv
// Randomized and directed stimulus for glycemic_alarm checked against a queue-based reference model.
module tb_glycemic_alarm;
    localparam int DEPTH   = 4;
    localparam int HIGH_TH = 6;
    localparam int LOW_TH  = 2;
    localparam int PERSIST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [3:0] glycemicIndex = '0;
    logic       ack = 1'b0;
    logic [3:0] avg_index;
    logic       avg_valid;
    logic [1:0] level;
    logic       alarm;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: the last DEPTH accepted samples plus the pipeline-visible results.
    int q[$];
    int exp_avg;
    bit exp_vld, exp_upd, pend_upd;
    int cur;   // -1 low, 0 normal, +1 high
    int cnt;
    bit alm;

    glycemic_alarm #(.WINDOW_LOG2(2), .HIGH_TH(HIGH_TH), .LOW_TH(LOW_TH), .PERSIST(PERSIST)) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .glycemicIndex (glycemicIndex),
        .ack           (ack),
        .avg_index     (avg_index),
        .avg_valid     (avg_valid),
        .level         (level),
        .alarm         (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    function automatic void model_reset();
        q.delete();
        exp_avg = 0; exp_vld = 0; exp_upd = 0; pend_upd = 0;
        cur = 0; cnt = 0; alm = 0;
    endfunction

    function automatic void model_edge(input bit sv, input int idx, input bit ak);
        int s, c;
        if (alm && ak) begin
            alm = 0; cur = 0; cnt = 0;
        end else if (exp_upd && !alm) begin
            if (exp_avg >= HIGH_TH) c = 1;
            else if (exp_avg <= LOW_TH) c = -1;
            else if (cur == 1 && exp_avg >= HIGH_TH - 1) c = 1;
            else if (cur == -1 && exp_avg <= LOW_TH + 1) c = -1;
            else c = 0;
            if (c == 0) cnt = 0;
            else if (c == cur) cnt = (cnt + 1 > PERSIST) ? PERSIST : cnt + 1;
            else cnt = 1;
            cur = c;
            alm = (cnt >= PERSIST);
        end
        s = 0;
        foreach (q[i]) s += q[i];
        exp_avg  = s / DEPTH;
        exp_vld  = (q.size() == DEPTH);
        exp_upd  = pend_upd;
        pend_upd = sv && (q.size() >= DEPTH - 1);
        if (sv) begin
            q.push_back(idx > 8 ? 8 : idx);
            if (q.size() > DEPTH) void'(q.pop_front());
        end
    endfunction

    function automatic int exp_level();
        return (cur == 1) ? 2 : (cur == -1) ? 0 : 1;
    endfunction

    task automatic step(input bit sv, input int idx, input bit ak);
        sample_valid  = sv;
        glycemicIndex = 4'(idx);
        ack           = ak;
        @(posedge clk);
        model_edge(sv, idx, ak);
        #1;
        check("avg_index", int'(avg_index), exp_avg);
        check("avg_valid", int'(avg_valid), int'(exp_vld));
        check("level", int'(level), exp_level());
        check("alarm", int'(alarm), int'(alm));
    endtask

    task automatic pulse_reset();
        sample_valid = 0; ack = 0;
        #3 rst = 1'b1;
        #1;
        model_reset();
        check("rst_avg_index", int'(avg_index), 0);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_level", int'(level), 1);
        check("rst_alarm", int'(alarm), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic samples(input int val, input int n);
        for (int i = 0; i < n; i++) step(1'b1, val, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        pulse_reset();

        samples(5, 4); idle(3);
        pulse_reset();

        samples(8, 6); samples(0, 3); idle(2);
        step(1'b1, 8, 1'b1); samples(8, 2); idle(3);

        pulse_reset();
        samples(6, 4); samples(2, 2); idle(3);
        pulse_reset();
        samples(2, 4); samples(6, 2); idle(3);

        pulse_reset();
        samples(15, 4); idle(3);
        pulse_reset();
        samples(3, 2);
        pulse_reset();
        samples(7, 3); samples(7, 1); idle(3);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) pulse_reset();
            else step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                      $urandom_range(0, 11) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
